// File: rtl/lcd_pixel_packer.sv
// lcd_pixel_packer: packs six 16-bit SDRAM read words into 96-bit entries,
// buffers them in a small FIFO and serves them to the LCD driver.
// Ports:
//   clk_lcd, lcd_rst_n          single clock, asynchronous active-low reset
//   in_valid/in_data/in_ready   16-bit upstream word stream (valid/ready)
//   rd_restart                  pulse asking the SDRAM side to reload the frame base
//   lcd_rden/lcd_data           pop request, popped entry one cycle later
//   sdr_addr_set                flush request
//   lcd_framesync               frame start, clears the per-frame underflow flag
//   fifo_level                  number of buffered entries
//   underflow                   sticky underrun flag for the current frame
//   underrun_cnt                saturating total underrun count
module lcd_pixel_packer #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk_lcd,
   input  logic                     lcd_rst_n,
   input  logic                     in_valid,
   input  logic [15:0]              in_data,
   output logic                     in_ready,
   output logic                     rd_restart,
   input  logic                     lcd_rden,
   output logic [95:0]              lcd_data,
   input  logic                     sdr_addr_set,
   input  logic                     lcd_framesync,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     underflow,
   output logic [CNT_W-1:0]         underrun_cnt
);
   localparam int AW = $clog2(DEPTH);

   logic [95:0]   mem [DEPTH];
   logic [79:0]   pack_reg;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [2:0]    pack_cnt;
   logic          flush_q, started;
   logic          accept, push, pop, empty_pop;

   // started keeps in_ready low until the first edge after reset release
   assign in_ready   = started && !flush_q && (pack_cnt != 3'd5 || fifo_level != (AW+1)'(DEPTH));
   assign rd_restart = flush_q;
   // a flush request masks any push or pop in the same cycle
   assign accept     = in_valid && in_ready && !sdr_addr_set;
   assign push       = accept && pack_cnt == 3'd5;
   assign pop        = lcd_rden && fifo_level != '0 && !sdr_addr_set;
   assign empty_pop  = lcd_rden && fifo_level == '0 && !sdr_addr_set;

   always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
      if (!lcd_rst_n) begin
         started      <= 1'b0;
         flush_q      <= 1'b0;
         pack_cnt     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         lcd_data     <= '0;
         underflow    <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         started <= 1'b1;
         flush_q <= sdr_addr_set;
         if (sdr_addr_set) begin
            pack_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
         end else begin
            if (accept) pack_cnt <= push ? 3'd0 : pack_cnt + 3'd1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
         end
         // an empty pop, or a pop swallowed by a flush, presents zeros
         if (lcd_rden) lcd_data <= pop ? mem[rd_ptr] : '0;
         if (empty_pop) underflow <= 1'b1;
         else if (lcd_framesync) underflow <= 1'b0;
         if (empty_pop && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
      end
   end

   // data path needs no reset: pack_cnt and the pointers define validity
   always_ff @(posedge clk_lcd) begin
      if (push) mem[wr_ptr] <= {in_data, pack_reg};
      for (int i = 0; i < 5; i++)
         if (accept && pack_cnt == 3'(i)) pack_reg[16*i +: 16] <= in_data;
   end
endmodule

// File: tb/tb_lcd_pixel_packer.sv
// tb_lcd_pixel_packer: directed self-checking bench for lcd_pixel_packer.
// Ports: none (drives every DUT port, CNT_W reduced to 4 so saturation is reachable).
module tb_lcd_pixel_packer;
   logic        clk_lcd = 0, lcd_rst_n = 0, in_valid = 0, lcd_rden = 0;
   logic        sdr_addr_set = 0, lcd_framesync = 0;
   logic [15:0] in_data = 0;
   logic        in_ready, rd_restart, underflow;
   logic [95:0] lcd_data;
   logic [3:0]  fifo_level;
   logic [3:0]  underrun_cnt;
   int          passed = 0, total = 0;

   always #5 clk_lcd = ~clk_lcd;

   lcd_pixel_packer #(.DEPTH(8), .CNT_W(4)) dut (
      .clk_lcd(clk_lcd), .lcd_rst_n(lcd_rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .rd_restart(rd_restart), .lcd_rden(lcd_rden), .lcd_data(lcd_data),
      .sdr_addr_set(sdr_addr_set), .lcd_framesync(lcd_framesync), .fifo_level(fifo_level),
      .underflow(underflow), .underrun_cnt(underrun_cnt)
   );

   task automatic step;
      @(posedge clk_lcd);
      #1;
   endtask

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [95:0] ent(input logic [15:0] b);
      return {b + 16'd5, b + 16'd4, b + 16'd3, b + 16'd2, b + 16'd1, b};
   endfunction

   task automatic send(input logic [15:0] d);
      in_valid = 1;
      in_data  = d;
      for (int t = 0; t < 40 && !in_ready; t++) step();
      chk("send_ready", in_ready, 1);
      step();
      in_valid = 0;
   endtask

   task automatic pop(input string tag, input logic [95:0] exp);
      lcd_rden = 1;
      step();
      lcd_rden = 0;
      chk(tag, lcd_data, exp);
   endtask

   initial begin
      #3;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_rd_restart", rd_restart, 0);
      chk("rst_lcd_data", lcd_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_cnt", underrun_cnt, 0);
      #9 lcd_rst_n = 1;
      step();
      chk("ready_after_rst", in_ready, 1);

      for (int i = 1; i <= 12; i++) send(16'(i));
      chk("basic_level", fifo_level, 2);
      pop("basic_pop0", 96'h0006_0005_0004_0003_0002_0001);
      pop("basic_pop1", 96'h000C_000B_000A_0009_0008_0007);
      step();
      chk("basic_hold", lcd_data, 96'h000C_000B_000A_0009_0008_0007);
      chk("basic_empty", fifo_level, 0);

      for (int i = 0; i < 48; i++) send(16'(16'h1000 + i));
      chk("full_level", fifo_level, 8);
      for (int i = 48; i < 53; i++) send(16'(16'h1000 + i));
      chk("full_level2", fifo_level, 8);
      chk("full_ready", in_ready, 0);
      in_valid = 1;
      in_data  = 16'h1035;
      step();
      chk("full_stall", in_ready, 0);
      lcd_rden = 1;
      step();
      lcd_rden = 0;
      chk("full_pop0", lcd_data, ent(16'h1000));
      chk("full_lvl7", fifo_level, 7);
      chk("full_ready_again", in_ready, 1);
      step();
      in_valid = 0;
      chk("full_54th", fifo_level, 8);
      for (int k = 1; k <= 8; k++) pop("full_drain", ent(16'(16'h1000 + 6*k)));
      chk("full_drained", fifo_level, 0);

      pop("ur_data", 0);
      chk("ur_flag", underflow, 1);
      chk("ur_cnt1", underrun_cnt, 1);
      lcd_framesync = 1;
      step();
      lcd_framesync = 0;
      chk("fs_clear", underflow, 0);
      chk("fs_cnt", underrun_cnt, 1);
      lcd_framesync = 1;
      lcd_rden = 1;
      step();
      lcd_framesync = 0;
      lcd_rden = 0;
      chk("fs_ur_wins", underflow, 1);
      chk("fs_ur_cnt2", underrun_cnt, 2);
      lcd_framesync = 1;
      step();
      lcd_framesync = 0;

      for (int i = 0; i < 24; i++) send(16'(16'h2000 + i));
      pop("fl_pre_pop", ent(16'h2000));
      send(16'h2018);
      send(16'h2019);
      chk("fl_level3", fifo_level, 3);
      sdr_addr_set = 1;
      lcd_rden = 1;
      step();
      sdr_addr_set = 0;
      lcd_rden = 0;
      chk("fl_level0", fifo_level, 0);
      chk("fl_restart", rd_restart, 1);
      chk("fl_data0", lcd_data, 0);
      chk("fl_no_ur_flag", underflow, 0);
      chk("fl_no_ur_cnt", underrun_cnt, 2);
      chk("fl_ready_low", in_ready, 0);
      step();
      chk("fl_ready_back", in_ready, 1);
      chk("fl_restart_end", rd_restart, 0);
      for (int i = 0; i < 6; i++) send(16'(16'h3000 + i));
      chk("fl_new_level", fifo_level, 1);
      pop("fl_new_entry", ent(16'h3000));

      sdr_addr_set = 1;
      step();
      chk("b2b_restart1", rd_restart, 1);
      step();
      sdr_addr_set = 0;
      chk("b2b_restart2", rd_restart, 1);
      chk("b2b_ready", in_ready, 0);
      step();
      chk("b2b_restart_end", rd_restart, 0);
      chk("b2b_ready_back", in_ready, 1);

      lcd_rden = 1;
      for (int i = 0; i < 13; i++) step();
      chk("sat_cnt15", underrun_cnt, 15);
      for (int i = 0; i < 3; i++) step();
      lcd_rden = 0;
      chk("sat_hold", underrun_cnt, 15);
      chk("sat_data", lcd_data, 0);

      for (int i = 0; i < 24; i++) send(16'(16'h4000 + i));
      chk("sim_level4", fifo_level, 4);
      for (int e = 4; e < 24; e++) begin
         for (int w = 0; w < 5; w++) send(16'(16'h4000 + 6*e + w));
         lcd_rden = 1;
         send(16'(16'h4000 + 6*e + 5));
         lcd_rden = 0;
         chk("sim_level", fifo_level, 4);
         chk("sim_data", lcd_data, ent(16'(16'h4000 + 6*(e-4))));
      end
      for (int e = 20; e < 24; e++) pop("sim_drain", ent(16'(16'h4000 + 6*e)));

      for (int i = 0; i < 7; i++) send(16'(16'h5000 + i));
      chk("ar_pre_level", fifo_level, 1);
      #2 lcd_rst_n = 0;
      #1;
      chk("ar_in_ready", in_ready, 0);
      chk("ar_rd_restart", rd_restart, 0);
      chk("ar_lcd_data", lcd_data, 0);
      chk("ar_level", fifo_level, 0);
      chk("ar_underflow", underflow, 0);
      chk("ar_cnt", underrun_cnt, 0);
      step();
      lcd_rst_n = 1;
      step();
      chk("ar_ready_back", in_ready, 1);
      for (int i = 0; i < 6; i++) send(16'(16'h6000 + i));
      pop("ar_fresh_entry", ent(16'h6000));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
